// File: rtl/seq_gen_serial.sv
// seq_gen_serial: serial pattern generator, LSB-first, valid/ready load.
// Optional pattern looping with `define SEQ_GEN_LOOP_EN (adds loop_en).
module seq_gen_serial #(
    parameter int WIDTH = 21,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
`ifdef SEQ_GEN_LOOP_EN
    input  logic             loop_en,
`endif
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] load_len,
    input  logic             hold,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       current_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SEND  = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] LP_MAXLEN = CNT_W'(WIDTH);

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_sh;
    logic [WIDTH-1:0]  r_pat;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  w_len_clamp;
    logic              w_last;
    logic              w_loop;

`ifdef SEQ_GEN_LOOP_EN
    assign w_loop = loop_en;
`else
    assign w_loop = 1'b0;
`endif

    // Zero or oversize lengths mean "send the full pattern".
    assign w_len_clamp = (load_len == '0 || load_len > LP_MAXLEN)
                         ? LP_MAXLEN : load_len;
    assign w_last      = (r_cnt == r_len - CNT_W'(1));

    assign dout          = r_sh[0];
    assign dout_valid    = (r_state == SEND);
    assign load_ready    = (r_state == IDLE);
    assign busy          = (r_state == SEND) || (r_state == PAUSE);
    assign done          = (r_state == DONE);
    assign current_state = r_state;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: hold stalls, last bit ends or restarts the pattern.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (load_valid) begin
                    w_next = SEND;
                end
            end
            SEND: begin
                if (hold) begin
                    w_next = PAUSE;
                end else if (w_last && !w_loop) begin
                    w_next = DONE;
                end
            end
            PAUSE: begin
                if (!hold) begin
                    w_next = SEND;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Datapath: capture on load, shift on each transferred bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sh  <= '0;
            r_pat <= '0;
            r_cnt <= '0;
            r_len <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load_valid) begin
                        r_sh  <= load_data;
                        r_pat <= load_data;
                        r_len <= w_len_clamp;
                        r_cnt <= '0;
                    end
                end
                SEND: begin
                    if (!hold) begin
                        if (w_last) begin
                            if (w_loop) begin
                                r_sh  <= r_pat;
                                r_cnt <= '0;
                            end
                        end else begin
                            r_sh  <= r_sh >> 1;
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen_serial.sv
// tb_seq_gen_serial: scoreboard bench for seq_gen_serial.
// Stimulus pushes expected bits; a monitor pops on each transferred bit.
module tb_seq_gen_serial;

    localparam int WIDTH = 21;
    localparam int CNT_W = 5;

    logic             clk;
    logic             reset;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [CNT_W-1:0] load_len;
    logic             hold;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             done;
    logic [1:0]       current_state;
`ifdef SEQ_GEN_LOOP_EN
    logic             loop_en;
`endif

    int n_checks;
    int n_fail;
    int done_cnt;
    bit exp_q[$];

    seq_gen_serial #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
`ifdef SEQ_GEN_LOOP_EN
        .loop_en       (loop_en),
`endif
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_data     (load_data),
        .load_len      (load_len),
        .hold          (hold),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .busy          (busy),
        .done          (done),
        .current_state (current_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a load; expected bits are pushed in LSB-first order.
    task automatic do_load(input logic [WIDTH-1:0] d,
                           input logic [CNT_W-1:0] len,
                           input int nbits);
        int guard;
        guard = 0;
        while (!load_ready && guard < 50) begin
            tick();
            guard++;
        end
        chk("load_ready_wait", {31'd0, load_ready}, 32'd1);
        load_valid = 1'b1;
        load_data  = d;
        load_len   = len;
        for (int i = 0; i < nbits; i++) exp_q.push_back(d[i]);
        tick();
        load_valid = 1'b0;
    endtask

    // Monitor: compare every transferred bit against the scoreboard.
    always @(negedge clk) begin
        if (reset && dout_valid && !hold) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_bit: got %0b expected none", dout);
            end else begin
                chk("dout_bit", {31'd0, dout}, {31'd0, exp_q.pop_front()});
            end
        end
        if (done) done_cnt++;
    end

    initial begin
        int exp_done;
        n_checks   = 0;
        n_fail     = 0;
        done_cnt   = 0;
        exp_done   = 0;
        reset      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_len   = '0;
        hold       = 1'b0;
`ifdef SEQ_GEN_LOOP_EN
        loop_en    = 1'b0;
`endif
        tick();
        tick();
        chk("rst_state", {30'd0, current_state}, 32'd0);
        chk("rst_dout", {31'd0, dout}, 32'd0);
        chk("rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ready", {31'd0, load_ready}, 32'd1);
        reset = 1'b1;
        tick();

        // Full 21-bit pattern, length 0 clamps to WIDTH.
        do_load(21'b110111010110100101101, 5'd0, 21);
        chk("t1_first_bit", {31'd0, dout}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        repeat (21) tick();
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_state_done", {30'd0, current_state}, 32'd3);
        exp_done++;
        tick();
        chk("t1_ready", {31'd0, load_ready}, 32'd1);
        chk("t1_done_off", {31'd0, done}, 32'd0);

        // Length 3 with two hold cycles on the second bit.
        do_load(21'h0000B, 5'd3, 3);
        chk("t2_s0", {30'd0, current_state}, 32'd1);
        tick();
        hold = 1'b1;
        chk("t2_s1", {30'd0, current_state}, 32'd1);
        tick();
        chk("t2_p1", {30'd0, current_state}, 32'd2);
        chk("t2_p1_valid", {31'd0, dout_valid}, 32'd0);
        chk("t2_p1_dout", {31'd0, dout}, 32'd1);
        chk("t2_p1_busy", {31'd0, busy}, 32'd1);
        tick();
        hold = 1'b0;
        chk("t2_p2", {30'd0, current_state}, 32'd2);
        chk("t2_p2_dout", {31'd0, dout}, 32'd1);
        tick();
        chk("t2_resume", {30'd0, current_state}, 32'd1);
        chk("t2_resume_dout", {31'd0, dout}, 32'd1);
        tick();
        chk("t2_last_dout", {31'd0, dout}, 32'd0);
        tick();
        chk("t2_done", {31'd0, done}, 32'd1);
        exp_done++;
        tick();

        // Load attempt while busy must be ignored.
        do_load(21'h0A5C3, 5'd0, 21);
        repeat (4) tick();
        load_valid = 1'b1;
        load_data  = 21'h1FFFFF;
        chk("t3_ready_busy", {31'd0, load_ready}, 32'd0);
        tick();
        load_valid = 1'b0;
        repeat (16) tick();
        chk("t3_done", {31'd0, done}, 32'd1);
        exp_done++;
        tick();

        // Reset on the 10th bit abandons the transfer.
        do_load(21'h15A3C, 5'd21, 21);
        repeat (9) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_q.delete();
        chk("t4_state", {30'd0, current_state}, 32'd0);
        chk("t4_dout", {31'd0, dout}, 32'd0);
        chk("t4_valid", {31'd0, dout_valid}, 32'd0);
        chk("t4_done", {31'd0, done}, 32'd0);
        chk("t4_ready", {31'd0, load_ready}, 32'd1);

        // Length 1 accepted right after reset.
        do_load(21'h00001, 5'd1, 1);
        chk("t5_state", {30'd0, current_state}, 32'd1);
        chk("t5_dout", {31'd0, dout}, 32'd1);
        tick();
        chk("t5_done", {31'd0, done}, 32'd1);
        exp_done++;
        tick();
        chk("t5_idle", {30'd0, current_state}, 32'd0);

`ifdef SEQ_GEN_LOOP_EN
        // Three passes of a 4-bit pattern with no gap, then one done.
        loop_en = 1'b1;
        do_load(21'b0110, 5'd4, 4);
        for (int i = 0; i < 8; i++) exp_q.push_back((4'b0110 >> (i % 4)) & 1'b1);
        repeat (8) tick();
        chk("t6_no_done", {31'd0, done}, 32'd0);
        chk("t6_still_send", {30'd0, current_state}, 32'd1);
        loop_en = 1'b0;
        repeat (4) tick();
        chk("t6_done", {31'd0, done}, 32'd1);
        exp_done++;
        tick();
`endif

        tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("done_pulses", done_cnt, exp_done);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
